// File: rtl/wb_mem_initiator.sv
// Wishbone pipelined-mode burst master driving one port of a BRAM-backed slave.
// Optional ack timeout abort: define WB_INITIATOR_TIMEOUT_EN.
module wb_mem_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_we,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    i_cmd_len,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  output logic [DATA_WIDTH/8-1:0] o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_n;
  logic                  we_q, we_n;
  logic [LEN_WIDTH-1:0]  len_q, len_n;
  logic [CW-1:0]         issued, issued_n;
  logic [CW-1:0]         acked, acked_n;
  logic [CW-1:0]         captured, captured_n;
  logic                  cyc, cyc_n;
  logic                  stb, stb_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n;
  logic                  rvalid, rvalid_n;
  logic                  done, done_n;
  logic                  err, err_n;

  logic                  accept, ack, abort, tmo_hit, wr_fire, cmd_fire;
  logic [CW-1:0]         total, issued_inc, acked_inc;

  assign total      = {1'b0, len_q} + CW'(1);
  assign accept     = stb & ~i_wb_stall;
  assign ack        = cyc & i_wb_ack;
  assign abort      = cyc & (i_wb_err | tmo_hit);
  assign issued_inc = issued + CW'(accept);
  assign acked_inc  = acked + CW'(ack);

  // Ready is withheld during the o_done cycle so a new command starts one cycle later.
  assign o_cmd_ready = (state == IDLE) & ~done;
  assign cmd_fire    = i_cmd_valid & o_cmd_ready;

  // A write word is taken only when the request register is free and words remain.
  assign wr_fire = (state == ISSUE) & we_q & i_wr_valid & (~stb | ~i_wb_stall)
                 & (captured != total) & ~abort;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !cyc || ack || accept) tmo <= '0;
    else                                   tmo <= tmo + TW'(1);
  end

  assign tmo_hit = cyc & ~ack & ~accept & (tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: the comparison is constant false for any legal setting.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // NOTE: every signal gets its default first, so no path through the case infers a latch.
  always_comb begin
    state_n    = state;
    we_n       = we_q;
    len_n      = len_q;
    issued_n   = issued;
    acked_n    = acked;
    captured_n = captured;
    cyc_n      = cyc;
    stb_n      = stb;
    addr_n     = addr;
    wdata_n    = wdata;
    rdata_n    = rdata;
    rvalid_n   = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          we_n       = i_cmd_we;
          len_n      = i_cmd_len;
          addr_n     = i_cmd_addr;
          issued_n   = '0;
          acked_n    = '0;
          captured_n = '0;
          cyc_n      = 1'b1;
          state_n    = ISSUE;
        end
      end

      ISSUE, DRAIN: begin
        issued_n = issued_inc;
        acked_n  = acked_inc;
        if (accept) addr_n = addr + ADDR_WIDTH'(1);
        if (ack && !we_q) begin
          rdata_n  = i_wb_data;
          rvalid_n = 1'b1;
        end
        if (wr_fire) begin
          wdata_n    = i_wr_data;
          captured_n = captured + CW'(1);
        end

        if (abort) begin
          cyc_n    = 1'b0;
          stb_n    = 1'b0;
          rvalid_n = 1'b0;
          done_n   = 1'b1;
          err_n    = 1'b1;
          state_n  = IDLE;
        end else if (issued_inc == total && acked_inc == total) begin
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (issued_inc == total) begin
          stb_n   = 1'b0;
          state_n = DRAIN;
        end else if (state == ISSUE) begin
          if (!we_q)        stb_n = 1'b1;
          else if (wr_fire) stb_n = 1'b1;
          else if (accept)  stb_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      len_q    <= '0;
      issued   <= '0;
      acked    <= '0;
      captured <= '0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      we_q     <= we_n;
      len_q    <= len_n;
      issued   <= issued_n;
      acked    <= acked_n;
      captured <= captured_n;
      cyc      <= cyc_n;
      stb      <= stb_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      rdata    <= rdata_n;
      rvalid   <= rvalid_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  assign o_wr_ready = wr_fire;
  assign o_rd_data  = rdata;
  assign o_rd_valid = rvalid;
  assign o_wb_cyc   = cyc;
  assign o_wb_stb   = stb;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr;
  assign o_wb_data  = wdata;
  assign o_wb_sel   = '1;
  assign o_done     = done;
  assign o_err      = err;

endmodule

// File: tb/tb_wb_mem_initiator.sv
// Self-checking bench for wb_mem_initiator: burst vector table plus no-ack/timeout and
// mid-burst reset sequences, against a small BRAM-style Wishbone slave model.
`timescale 1ns/1ps
module tb_wb_mem_initiator;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [DW/8-1:0] wb_sel;
  logic          wb_stall;
  logic          wb_ack = 1'b0, wb_err = 1'b0;
  logic [DW-1:0] wb_rdata = '0;
  logic          done, err;

  always #5 clk = ~clk;

  wb_mem_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
    .o_done(done), .o_err(err)
  );

  // Slave model: zero-wait BRAM, registered ack/data, scripted stall and error injection.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int req_idx = 0, ack_idx = 0, stall_seen = 0, cyc_cnt = 0;
  int stall_at = -1, stall_limit = 0, err_at = -1;
  bit no_ack = 1'b0;

  assign wb_stall = wb_stb && (req_idx == stall_at) && (stall_seen < stall_limit);

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    wb_ack  <= 1'b0;
    wb_err  <= 1'b0;
    if (wb_cyc && wb_stb && !wb_stall) begin
      req_idx <= req_idx + 1;
      if (wb_we) mem[wb_addr] <= wb_wdata;
      wb_rdata <= mem[wb_addr];
      if (!no_ack) begin
        ack_idx <= ack_idx + 1;
        if (ack_idx == err_at) wb_err <= 1'b1;
        else                   wb_ack <= 1'b1;
      end
    end
    if (wb_stb && wb_stall) stall_seen <= stall_seen + 1;
  end

  // Monitor: accepted requests, read words, done pulses, stall-hold violations.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } req_t;

  req_t          req_q[$];
  logic [DW-1:0] rd_q[$];
  int            done_cnt = 0, done_cyc = 0, stb_total = 0, hold_viol = 0;
  logic          prev_hold = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_hold && !(wb_stb && wb_addr == prev_addr && wb_wdata == prev_data && wb_we == prev_we))
      hold_viol <= hold_viol + 1;
    prev_hold <= wb_stb && wb_stall;
    prev_addr <= wb_addr;
    prev_data <= wb_wdata;
    prev_we   <= wb_we;
    if (wb_stb) stb_total <= stb_total + 1;
    if (wb_stb && !wb_stall) req_q.push_back('{we: wb_we, addr: wb_addr, data: wb_wdata, cyc: cyc_cnt});
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cyc"}, wb_cyc, 0);
    check({tag, "_stb"}, wb_stb, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_addr"}, wb_addr, 0);
    check({tag, "_wdata"}, wb_wdata, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  task automatic issue_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           output int acc);
    int guard = 0;
    @(negedge clk); #1;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", guard < 50, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    acc       = cyc_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] base;      // first write word, or first expected read word
    int            stall_req; // request index stalled for two cycles, -1 none
    int            gap;       // wr_valid low cycles after the first word
    int            err_ack;   // response index answered with err, -1 none
    int            exp_reqs;
    int            exp_stb;
    int            exp_rd;
    bit            exp_err;
    logic [AW-1:0] exp_last;  // address of the last accepted request
  } vec_t;

  task automatic run_burst(input int idx, input vec_t v);
    int rq_base, rd_base, d_base, s_base, hv_base, acc, k, gap_left, drops, n;
    bit seen;
    logic [AW-1:0] a;
    string p;
    p       = $sformatf("v%0d", idx);
    rq_base = req_q.size();
    rd_base = rd_q.size();
    d_base  = done_cnt;
    s_base  = stb_total;
    hv_base = hold_viol;
    stall_at    = (v.stall_req >= 0) ? req_idx + v.stall_req : -1;
    stall_limit = stall_seen + 2;
    err_at      = (v.err_ack >= 0) ? ack_idx + v.err_ack : -1;
    issue_cmd(v.we, v.addr, v.len, acc);
    k = 0; gap_left = 0; drops = 0; seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (v.we && k <= int'(v.len) && gap_left == 0) begin
        wr_valid = 1'b1;
        wr_data  = v.base + DW'(k);
      end else begin
        wr_valid = 1'b0;
      end
      if (gap_left > 0) gap_left--;
      #1;
      if (wr_valid && wr_ready) begin
        k++;
        if (k == 1) gap_left = v.gap;
      end
      if (done_cnt != d_base) begin
        seen = 1'b1;
        break;
      end
      if (!wb_cyc) drops++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check({p, "_done_seen"}, seen, 1);
    check({p, "_err"}, err, v.exp_err);
    check({p, "_ready_in_done"}, cmd_ready, 0);
    check({p, "_cyc_drops"}, drops, 0);
    @(negedge clk); #1;
    check({p, "_cyc_after_done"}, wb_cyc, 0);
    check({p, "_ready_after_done"}, cmd_ready, 1);
    check({p, "_done_count"}, done_cnt - d_base, 1);
    check({p, "_reqs"}, req_q.size() - rq_base, v.exp_reqs);
    check({p, "_stb_cycles"}, stb_total - s_base, v.exp_stb);
    check({p, "_rd_words"}, rd_q.size() - rd_base, v.exp_rd);
    check({p, "_hold"}, hold_viol - hv_base, 0);
    if (req_q.size() > rq_base) begin
      check({p, "_latency"}, req_q[rq_base].cyc - acc, 2);
      check({p, "_last_addr"}, req_q[req_q.size()-1].addr, v.exp_last);
    end
    n = req_q.size() - rq_base;
    a = v.addr;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", p, i), req_q[rq_base+i].addr, a);
      check($sformatf("%s_we%0d", p, i), req_q[rq_base+i].we, v.we);
      if (v.we) check($sformatf("%s_wdata%0d", p, i), req_q[rq_base+i].data, v.base + DW'(i));
      a = a + AW'(1);
    end
    n = rd_q.size() - rd_base;
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rdata%0d", p, i), rd_q[rd_base+i], v.base + DW'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t fin;
    int   acc, d0;

    vecs[0] = '{1, 10'h010, 8'd3, 32'hA0, -1, 0, -1, 4, 4, 0, 0, 10'h013};
    vecs[1] = '{0, 10'h010, 8'd3, 32'hA0, -1, 0, -1, 4, 4, 4, 0, 10'h013};
    vecs[2] = '{1, 10'h3FE, 8'd3, 32'hB0, -1, 0, -1, 4, 4, 0, 0, 10'h001};
    vecs[3] = '{0, 10'h3FE, 8'd3, 32'hB0,  1, 0, -1, 4, 6, 4, 0, 10'h001};
    vecs[4] = '{1, 10'h200, 8'd1, 32'hD0, -1, 3, -1, 2, 2, 0, 0, 10'h201};
    vecs[5] = '{0, 10'h200, 8'd1, 32'hD0, -1, 0, -1, 2, 2, 2, 0, 10'h201};
    vecs[6] = '{0, 10'h010, 8'd3, 32'hA0, -1, 0,  1, 3, 3, 1, 1, 10'h012};
    vecs[7] = '{0, 10'h013, 8'd0, 32'hA3, -1, 0, -1, 1, 1, 1, 0, 10'h013};
    vecs[8] = '{1, 10'h3FF, 8'd0, 32'hE0, -1, 0, -1, 1, 1, 0, 0, 10'h3FF};
    vecs[9] = '{0, 10'h3FF, 8'd0, 32'hE0, -1, 0, -1, 1, 1, 1, 0, 10'h3FF};
    fin     = '{0, 10'h010, 8'd3, 32'hA0, -1, 0, -1, 4, 4, 4, 0, 10'h013};

    repeat (3) @(negedge clk);
    #1;
    check_idle("in_reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_idle("after_reset");
    check("sel_all_ones", wb_sel, 4'hF);

    for (int i = 0; i < 10; i++) run_burst(i, vecs[i]);

    // Slave stops acking: a single read either times out or waits forever.
    no_ack = 1'b1;
    d0 = done_cnt;
    issue_cmd(1'b0, 10'h010, 8'd0, acc);
`ifdef WB_INITIATOR_TIMEOUT_EN
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    check("tmo_done", done_cnt - d0, 1);
    check("tmo_err", err, 1);
    check("tmo_cyc", wb_cyc, 0);
    check("tmo_cycle", done_cyc - acc, 11);
    d0 = done_cnt;
    issue_cmd(1'b0, 10'h010, 8'd0, acc);
    repeat (3) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    #1;
    check("noack_no_done", done_cnt - d0, 0);
    check("noack_cyc_held", wb_cyc, 1);
`endif

    // Reset in the middle of an open cycle.
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_idle("rst_mid");
    rst_n  = 1'b1;
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);

    run_burst(10, fin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
